// File: rtl/fcvtsw_pipe_if.sv
// Handshake and data bundle for the pipelined int-to-binary32 converter.
// The core side drives operands as master; the converter is the slave.
interface fcvtsw_pipe_if #(
   parameter int TAG_W = 5
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      x;
   logic             is_unsigned;
   logic [2:0]       rm;
   logic [TAG_W-1:0] tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      y;
   logic             nx;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, x, is_unsigned, rm, tag, out_ready,
      input  in_ready, out_valid, y, nx, out_tag
   );

   modport slave (
      input  in_valid, x, is_unsigned, rm, tag, out_ready,
      output in_ready, out_valid, y, nx, out_tag
   );
endinterface

// File: rtl/fcvtsw_pipe.sv
// Pipelined 32-bit signed/unsigned integer to IEEE-754 binary32 converter.
// Three combinational steps (abs, normalise, round+pack) are split across
// LATENCY register stages; the last stage is always the output register.
// A single global advance (adv) stalls every stage together, so the pipe
// never reorders, drops or duplicates operations.
module fcvtsw_pipe #(
   parameter int LATENCY = 2,
   parameter int TAG_W   = 5
) (
   input logic           clk,
   input logic           rstn,
   fcvtsw_pipe_if.slave  bus
);

   typedef struct packed {
      logic             s;
      logic [31:0]      m;
      logic [2:0]       rm;
      logic [TAG_W-1:0] tag;
   } abs_t;

   typedef struct packed {
      logic             s;
      logic             zero;
      logic [7:0]       e;
      logic [31:0]      n;
      logic [2:0]       rm;
      logic [TAG_W-1:0] tag;
   } norm_t;

   // Returns 31 - (index of highest set bit); result is unused when v == 0.
   function automatic logic [4:0] lzc32(input logic [31:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) c = 5'(31 - i);
      end
      return c;
   endfunction

   logic             adv;
   logic             out_valid_q;
   logic [31:0]      y_q;
   logic             nx_q;
   logic [TAG_W-1:0] out_tag_q;

   abs_t  a_d, a_o;
   logic  va_o;
   norm_t b_d, b_o;
   logic  vb_o;

   logic [31:0]      y_d;
   logic             nx_d;

   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.nx        = nx_q;
   assign bus.out_tag   = out_tag_q;

   // Step 1: sign and magnitude. Negating 0x80000000 wraps back to 2^31,
   // which is exactly the magnitude needed.
   always_comb begin
      a_d.s   = !bus.is_unsigned && bus.x[31];
      a_d.m   = a_d.s ? (~bus.x + 32'd1) : bus.x;
      a_d.rm  = bus.rm;
      a_d.tag = bus.tag;
   end

   generate
      if (LATENCY >= 3) begin : g_reg_abs
         abs_t a_q;
         logic va_q;
         // Register between abs and normalise (3-stage split only).
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               a_q  <= '0;
               va_q <= 1'b0;
            end else if (adv) begin
               a_q  <= a_d;
               va_q <= bus.in_valid;
            end
         end
         assign a_o  = a_q;
         assign va_o = va_q;
      end else begin : g_pass_abs
         assign a_o  = a_d;
         assign va_o = bus.in_valid;
      end
   endgenerate

   // Step 2: normalise so the leading one sits at bit 31.
   always_comb begin
      logic [4:0] lz;
      lz       = lzc32(a_o.m);
      b_d.s    = a_o.s;
      b_d.zero = (a_o.m == 32'd0);
      b_d.e    = 8'd158 - {3'b000, lz};
      b_d.n    = a_o.m << lz;
      b_d.rm   = a_o.rm;
      b_d.tag  = a_o.tag;
   end

   generate
      if (LATENCY >= 2) begin : g_reg_norm
         norm_t b_q;
         logic  vb_q;
         // Register between normalise and round/pack.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               b_q  <= '0;
               vb_q <= 1'b0;
            end else if (adv) begin
               b_q  <= b_d;
               vb_q <= va_o;
            end
         end
         assign b_o  = b_q;
         assign vb_o = vb_q;
      end else begin : g_pass_norm
         assign b_o  = b_d;
         assign vb_o = va_o;
      end
   endgenerate

   // Step 3: round per rm (reserved codes fall back to RNE) and pack.
   // A carry out of the significand can only come from 0xFFFFFF, so the
   // result is 1.0 x 2^(e+1); e tops out at 159, never reaching infinity.
   always_comb begin
      logic [23:0] sig;
      logic        guard;
      logic        sticky;
      logic        up;
      logic [24:0] sum;
      logic [22:0] mant;
      logic [7:0]  e;
      sig    = b_o.n[31:8];
      guard  = b_o.n[7];
      sticky = |b_o.n[6:0];
      case (b_o.rm)
         3'b001:  up = 1'b0;
         3'b010:  up = b_o.s && (guard || sticky);
         3'b011:  up = !b_o.s && (guard || sticky);
         3'b100:  up = guard;
         default: up = guard && (sticky || sig[0]);
      endcase
      sum = {1'b0, sig} + 25'(up);
      if (sum[24]) begin
         mant = 23'd0;
         e    = b_o.e + 8'd1;
      end else begin
         mant = sum[22:0];
         e    = b_o.e;
      end
      if (b_o.zero) begin
         y_d  = 32'd0;
         nx_d = 1'b0;
      end else begin
         y_d  = {b_o.s, e, mant};
         nx_d = guard || sticky;
      end
   end

   // Output register; data only updates on a real result so idle outputs stay put.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         y_q         <= 32'd0;
         nx_q        <= 1'b0;
         out_tag_q   <= '0;
      end else if (adv) begin
         out_valid_q <= vb_o;
         if (vb_o) begin
            y_q       <= y_d;
            nx_q      <= nx_d;
            out_tag_q <= b_o.tag;
         end
      end
   end

endmodule

// File: tb/tb_fcvtsw_pipe.sv
// Bench for fcvtsw_pipe: three instances (LATENCY 1, 2, 3) share one
// stimulus stream; each has its own scoreboard queue fed at acceptance
// and drained at output transfer.
module tb_fcvtsw_pipe;
   localparam int TW = 5;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid    = 1'b0;
   logic [31:0]   x           = 32'd0;
   logic          is_unsigned = 1'b0;
   logic [2:0]    rm          = 3'd0;
   logic [TW-1:0] tag         = '0;
   logic          out_ready   = 1'b0;
   logic [31:0]   exp_y       = 32'd0;
   logic          exp_nx      = 1'b0;
   logic          lat_chk     = 1'b0;

   logic [2:0]    ov, ir, nxv;
   logic [31:0]   yv [3];
   logic [TW-1:0] tg [3];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fcvtsw_pipe_if #(.TAG_W(TW)) bus ();
      assign bus.in_valid    = in_valid;
      assign bus.x           = x;
      assign bus.is_unsigned = is_unsigned;
      assign bus.rm          = rm;
      assign bus.tag         = tag;
      assign bus.out_ready   = out_ready;
      assign ov[g]  = bus.out_valid;
      assign ir[g]  = bus.in_ready;
      assign yv[g]  = bus.y;
      assign nxv[g] = bus.nx;
      assign tg[g]  = bus.out_tag;
      fcvtsw_pipe #(.LATENCY(g + 1), .TAG_W(TW)) u_dut (
         .clk  (clk),
         .rstn (rstn),
         .bus  (bus)
      );
   end

   typedef struct {
      logic [31:0]   y;
      logic          nx;
      logic [TW-1:0] tag;
      int            cyc;
   } exp_t;
   typedef exp_t exp_q_t[$];
   exp_q_t sb [3];

   typedef struct {
      logic [31:0] x;
      logic        uns;
      logic [2:0]  rm;
      logic [31:0] y;
      logic        nx;
   } vec_t;
   vec_t vecs [16];

   // Reference: locate the top bit, shift right, and round on the exact
   // discarded remainder compared against one half ulp.
   function automatic logic [32:0] model(input logic [31:0] xi, input logic uns,
                                         input logic [2:0] r);
      logic        s;
      logic [63:0] m, mant, remv, half;
      int          p, sh;
      logic        up;
      logic [7:0]  ex;
      s = !uns && xi[31];
      m = {32'd0, (s ? -xi : xi)};
      if (m == 64'd0) return 33'd0;
      p = 31;
      while (m[p] == 1'b0) p--;
      ex = 8'(127 + p);
      if (p <= 23) begin
         mant = m << (23 - p);
         remv = 64'd0;
         half = 64'd1;
      end else begin
         sh   = p - 23;
         mant = m >> sh;
         remv = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
      end
      case (r)
         3'd1:    up = 1'b0;
         3'd2:    up = s && (remv != 0);
         3'd3:    up = !s && (remv != 0);
         3'd4:    up = (remv >= half);
         default: up = (remv > half) || ((remv == half) && mant[0]);
      endcase
      mant = mant + 64'(up);
      if (mant[24]) begin
         mant = 64'h80_0000;
         ex   = ex + 8'd1;
      end
      return {(remv != 0), s, ex, mant[22:0]};
   endfunction

   task automatic chk(input string nm, input int inst, input logic [63:0] act,
                      input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut_lat%0d: got %0h expected %0h", nm, inst + 1, act, expv);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] xx, input logic u,
                        input logic [2:0] r, input logic [TW-1:0] t,
                        input logic [31:0] ey, input logic enx);
      in_valid    = v;
      x           = xx;
      is_unsigned = u;
      rm          = r;
      tag         = t;
      exp_y       = ey;
      exp_nx      = enx;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_model(input logic [31:0] xx, input logic u, input logic [2:0] r,
                              input logic [TW-1:0] t);
      logic [32:0] mr;
      mr = model(xx, u, r);
      drive(1'b1, xx, u, r, t, mr[31:0], mr[32]);
   endtask

   task automatic drain(input string nm);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 3; i++) begin
         chk({nm, "_pending"}, i, sb[i].size(), 0);
         chk({nm, "_idle_valid"}, i, ov[i], 0);
      end
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] r;
      case ($urandom_range(0, 3))
         0:       r = $urandom;
         1:       r = $urandom >> $urandom_range(0, 31);
         2:       r = -($urandom >> $urandom_range(0, 31));
         default: r = (32'd1 << $urandom_range(0, 31)) ^ 32'($urandom_range(0, 3));
      endcase
      return r;
   endfunction

   initial begin
      exp_t me;

      vecs[0]  = '{32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0};
      vecs[1]  = '{32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0};
      vecs[2]  = '{32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0};
      vecs[3]  = '{32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0};
      vecs[4]  = '{32'h0000_0000, 1'b0, 3'd3, 32'h0000_0000, 1'b0};
      vecs[5]  = '{32'h8000_0000, 1'b1, 3'd0, 32'h4F00_0000, 1'b0};
      vecs[6]  = '{32'h7FFF_FFFF, 1'b0, 3'd0, 32'h4F00_0000, 1'b1};
      vecs[7]  = '{32'h7FFF_FFFF, 1'b0, 3'd1, 32'h4EFF_FFFF, 1'b1};
      vecs[8]  = '{32'h8000_0001, 1'b0, 3'd2, 32'hCF00_0000, 1'b1};
      vecs[9]  = '{32'h8000_0001, 1'b0, 3'd3, 32'hCEFF_FFFF, 1'b1};
      vecs[10] = '{32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1};
      vecs[11] = '{32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1};
      vecs[12] = '{32'h0100_0003, 1'b0, 3'd0, 32'h4B80_0002, 1'b1};
      vecs[13] = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1};
      vecs[14] = '{32'hFFFF_FFFF, 1'b1, 3'd1, 32'h4F7F_FFFF, 1'b1};
      vecs[15] = '{32'h0100_0001, 1'b0, 3'd7, 32'h4B80_0000, 1'b1};

      #2;
      for (int i = 0; i < 3; i++) begin
         chk("rst_out_valid", i, ov[i], 0);
         chk("rst_in_ready", i, ir[i], 1);
         chk("rst_y", i, yv[i], 0);
         chk("rst_nx", i, nxv[i], 0);
         chk("rst_out_tag", i, tg[i], 0);
      end

      fork
         forever begin
            @(negedge clk);
            if (rstn) begin
               for (int i = 0; i < 3; i++) begin
                  if (ov[i]) begin
                     if (sb[i].size() == 0) begin
                        chk("unexpected_out", i, ov[i], 0);
                     end else begin
                        me = sb[i][0];
                        chk("y", i, yv[i], me.y);
                        chk("nx", i, nxv[i], me.nx);
                        chk("out_tag", i, tg[i], me.tag);
                        if (out_ready) begin
                           if (lat_chk) chk("latency", i, cyc - me.cyc, i + 1);
                           void'(sb[i].pop_front());
                        end
                     end
                  end
                  if (in_valid && ir[i]) begin
                     me.y   = exp_y;
                     me.nx  = exp_nx;
                     me.tag = tag;
                     me.cyc = cyc;
                     sb[i].push_back(me);
                  end
               end
            end
         end
      join_none

      @(posedge clk);
      #1;
      rstn      = 1'b1;
      out_ready = 1'b1;

      // Directed vectors, issued back to back.
      lat_chk = 1'b1;
      for (int k = 0; k < 16; k++)
         drive(1'b1, vecs[k].x, vecs[k].uns, vecs[k].rm, TW'(k), vecs[k].y, vecs[k].nx);
      drain("table");

      // Random streaming at full throughput.
      for (int k = 0; k < 4100; k++)
         drive_model(rand_operand(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), TW'(k));
      drain("stream");

      // Backpressure: fill, hold out_ready low for 5 cycles, then drain.
      lat_chk = 1'b0;
      for (int k = 0; k < 6; k++)
         drive_model(rand_operand(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), TW'(k + 8));
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         for (int i = 0; i < 3; i++) chk("stall_in_ready", i, ir[i], 0);
         @(posedge clk);
         #1;
      end
      drain("backpressure");

      // Asynchronous reset with operations in flight.
      lat_chk = 1'b1;
      drive_model(32'h0000_1234, 1'b0, 3'd0, TW'(20));
      drive_model(32'hFFFF_0000, 1'b0, 3'd0, TW'(21));
      in_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_out_valid", i, ov[i], 0);
         chk("mid_rst_in_ready", i, ir[i], 1);
         chk("mid_rst_y", i, yv[i], 0);
         chk("mid_rst_out_tag", i, tg[i], 0);
         sb[i].delete();
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(1'b1, 32'h0000_0003, 1'b1, 3'd0, TW'(25), 32'h4040_0000, 1'b0);
      drain("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
